// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: walks a layer's output-channel tiles through weight load and conv start/done handshake
module conv_tile_scheduler #(
  parameter int unsigned TILE_W = 8,
  parameter int unsigned TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [15:0]       desc_width_strips,
  input  logic [15:0]       desc_height,
  input  logic [TILE_W:0]   desc_num_tiles,
  input  logic              desc_last,
  output logic              wt_req,
  output logic [TILE_W-1:0] wt_tile_idx,
  input  logic              wt_ack,
  output logic              conv_start,
  output logic [15:0]       conv_img_width_strips,
  output logic [15:0]       conv_img_height,
  input  logic              conv_done,
  output logic [TILE_W-1:0] cur_tile,
  output logic              busy,
  output logic              layer_done,
  output logic              net_done,
  output logic              err_desc,
  output logic              err_timeout
);
  typedef enum logic [2:0] {S_IDLE, S_WT, S_START, S_RUN, S_REL} state_t;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);
  state_t              state_q, state_d;
  logic [TILE_W-1:0]   cur_tile_q, cur_tile_d;
  logic [TILE_W:0]     num_tiles_q, num_tiles_d;
  logic                last_q, last_d;
  logic [15:0]         width_q, width_d, height_q, height_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                layer_done_d, net_done_d, err_desc_d, err_timeout_d;
  logic                desc_ready_q, wt_req_q, conv_start_q, busy_q;
  logic                layer_done_q, net_done_q, err_desc_q, err_timeout_q;
  logic                desc_ok, tile_last;
  assign desc_ok   = |desc_width_strips && |desc_height && |desc_num_tiles;
  assign tile_last = {1'b0, cur_tile_q} == num_tiles_q - (TILE_W+1)'(1);
  assign desc_ready            = desc_ready_q;
  assign wt_req                = wt_req_q;
  assign wt_tile_idx           = cur_tile_q;
  assign cur_tile              = cur_tile_q;
  assign conv_start            = conv_start_q;
  assign conv_img_width_strips = width_q;
  assign conv_img_height       = height_q;
  assign busy                  = busy_q;
  assign layer_done            = layer_done_q;
  assign net_done              = net_done_q;
  assign err_desc              = err_desc_q;
  assign err_timeout           = err_timeout_q;
  // next-state: descriptor latch, tile sequencing and watchdog abort
  always_comb begin
    state_d       = state_q;
    cur_tile_d    = cur_tile_q;
    num_tiles_d   = num_tiles_q;
    last_d        = last_q;
    width_d       = width_q;
    height_d      = height_q;
    wdog_d        = wdog_q;
    layer_done_d  = 1'b0;
    net_done_d    = 1'b0;
    err_desc_d    = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      S_IDLE: if (desc_valid && desc_ready_q) begin
        err_desc_d = !desc_ok;
        if (desc_ok) begin
          width_d     = desc_width_strips;
          height_d    = desc_height;
          num_tiles_d = desc_num_tiles;
          last_d      = desc_last;
          cur_tile_d  = '0;
          state_d     = S_WT;
        end
      end
      S_WT: state_d = (wt_req_q && wt_ack) ? S_START : S_WT;
      S_START: begin
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wdog_d = &wdog_q ? wdog_q : wdog_q + TIMEOUT_W'(1);
        if (conv_done) state_d = S_REL;
        else if (TIMEOUT_CYCLES != '0 && wdog_q == WD_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_REL: if (!conv_done) begin
        layer_done_d = tile_last;
        net_done_d   = tile_last && last_q;
        cur_tile_d   = tile_last ? cur_tile_q : cur_tile_q + TILE_W'(1);
        state_d      = tile_last ? S_IDLE : S_WT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state, latched descriptor and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cur_tile_q    <= '0;
      num_tiles_q   <= '0;
      last_q        <= 1'b0;
      width_q       <= '0;
      height_q      <= '0;
      wdog_q        <= '0;
      desc_ready_q  <= 1'b0;
      wt_req_q      <= 1'b0;
      conv_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
      net_done_q    <= 1'b0;
      err_desc_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_tile_q    <= cur_tile_d;
      num_tiles_q   <= num_tiles_d;
      last_q        <= last_d;
      width_q       <= width_d;
      height_q      <= height_d;
      wdog_q        <= wdog_d;
      desc_ready_q  <= state_d == S_IDLE;
      wt_req_q      <= state_d == S_WT;
      conv_start_q  <= state_d == S_RUN;
      busy_q        <= state_d != S_IDLE;
      layer_done_q  <= layer_done_d;
      net_done_q    <= net_done_d;
      err_desc_q    <= err_desc_d;
      err_timeout_q <= err_timeout_d;
    end
  end
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// tb_conv_tile_scheduler: directed and randomized layers checked against descriptor-level expectations
module tb_conv_tile_scheduler;
  logic clk = 0, rst_n = 0;
  logic desc_valid = 0, desc_last = 0, wt_ack = 0, conv_done = 0;
  logic [15:0] desc_width_strips = 0, desc_height = 0;
  logic [8:0] desc_num_tiles = 0;
  logic desc_ready, wt_req, conv_start, busy, layer_done, net_done, err_desc, err_timeout;
  logic [7:0] wt_tile_idx, cur_tile;
  logic [15:0] conv_img_width_strips, conv_img_height;
  int checks = 0, errors = 0;
  int n_start = 0, n_ld = 0, n_nd = 0;
  logic cs_prev = 0;
  logic [15:0] exp_w = 0, exp_h = 0;

  conv_tile_scheduler #(.TILE_W(8), .TIMEOUT_W(24), .TIMEOUT_CYCLES(24'd20)) dut (
    .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_width_strips(desc_width_strips), .desc_height(desc_height),
    .desc_num_tiles(desc_num_tiles), .desc_last(desc_last), .wt_req(wt_req),
    .wt_tile_idx(wt_tile_idx), .wt_ack(wt_ack), .conv_start(conv_start),
    .conv_img_width_strips(conv_img_width_strips), .conv_img_height(conv_img_height),
    .conv_done(conv_done), .cur_tile(cur_tile), .busy(busy), .layer_done(layer_done),
    .net_done(net_done), .err_desc(err_desc), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (conv_start && !cs_prev) n_start++;
    cs_prev = conv_start;
    n_ld += int'(layer_done);
    n_nd += int'(net_done);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int s);
    return s == 0 ? wt_req : s == 1 ? conv_start : desc_ready;
  endfunction

  task automatic wait_hi(input int s, input string tag);
    int n = 0;
    while (sig(s) !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sig(s)), 1);
  endtask

  task automatic send_desc(input logic [15:0] w, input logic [15:0] h, input int n, input bit last);
    wait_hi(2, "desc_ready_wait");
    desc_width_strips = w;
    desc_height = h;
    desc_num_tiles = 9'(n);
    desc_last = last;
    desc_valid = 1;
    @(negedge clk);
    desc_valid = 0;
    exp_w = w;
    exp_h = h;
    chk("accept_w", 32'(conv_img_width_strips), 32'(w));
    chk("accept_h", 32'(conv_img_height), 32'(h));
    chk("accept_busy", 32'(busy), 1);
    chk("accept_ready", 32'(desc_ready), 0);
  endtask

  task automatic send_bad(input int which);
    wait_hi(2, "bad_ready_wait");
    desc_width_strips = which == 0 ? 16'd0 : 16'(1 + $urandom_range(0, 999));
    desc_height = which == 1 ? 16'd0 : 16'(1 + $urandom_range(0, 999));
    desc_num_tiles = which == 2 ? 9'd0 : 9'(1 + $urandom_range(0, 7));
    desc_last = 1'($urandom);
    desc_valid = 1;
    @(negedge clk);
    desc_valid = 0;
    chk("bad_err", 32'(err_desc), 1);
    chk("bad_ready", 32'(desc_ready), 1);
    chk("bad_wtreq", 32'(wt_req), 0);
    chk("bad_w_hold", 32'(conv_img_width_strips), 32'(exp_w));
    chk("bad_h_hold", 32'(conv_img_height), 32'(exp_h));
    @(negedge clk);
    chk("bad_pulse", 32'(err_desc), 0);
    chk("bad_busy", 32'(busy), 0);
  endtask

  task automatic do_tile(input int t, input int ack_lat, input bit stale, input int run, input int hold,
                         input bit last_tile, input bit net);
    wait_hi(0, "wt_req_wait");
    chk("wt_idx", 32'(wt_tile_idx), 32'(t));
    chk("cur_tile", 32'(cur_tile), 32'(t));
    if (stale) conv_done = 1;
    repeat (ack_lat) @(negedge clk);
    wt_ack = 1;
    @(negedge clk);
    wt_ack = 0;
    chk("wt_req_drop", 32'(wt_req), 0);
    wait_hi(1, "conv_start_wait");
    if (stale) begin
      @(negedge clk);
      chk("stale_start_drop", 32'(conv_start), 0);
      repeat (hold) begin
        @(negedge clk);
        chk("stale_hold_wtreq", 32'(wt_req), 0);
        chk("stale_hold_busy", 32'(busy), 1);
      end
    end else begin
      repeat (run) begin
        @(negedge clk);
        chk("run_start_held", 32'(conv_start), 1);
      end
      conv_done = 1;
      repeat (hold) @(negedge clk);
      chk("done_start_drop", 32'(conv_start), 0);
    end
    conv_done = 0;
    @(negedge clk);
    chk("layer_done", 32'(layer_done), 32'(last_tile));
    chk("net_done", 32'(net_done), 32'(last_tile && net));
    chk("end_ready", 32'(desc_ready), 32'(last_tile));
    if (!last_tile) chk("next_wt_req", 32'(wt_req), 1);
  endtask

  task automatic run_layer(input logic [15:0] w, input logic [15:0] h, input int n, input bit last,
                           input int ack_lat, input int run, input int hold, input bit stale_first, input bit rnd);
    int s0 = n_start, l0 = n_ld, d0 = n_nd;
    send_desc(w, h, n, last);
    for (int t = 0; t < n; t++)
      do_tile(t, rnd ? int'($urandom_range(0, 5)) : ack_lat,
              rnd ? ($urandom_range(0, 3) == 0) : (stale_first && t == 0),
              rnd ? int'($urandom_range(0, 4)) : run,
              rnd ? int'($urandom_range(1, 3)) : hold, t == n - 1, last);
    repeat (2) @(negedge clk);
    chk("start_edges", 32'(n_start - s0), 32'(n));
    chk("layer_done_cnt", 32'(n_ld - l0), 1);
    chk("net_done_cnt", 32'(n_nd - d0), 32'(last));
    chk("img_w_stable", 32'(conv_img_width_strips), 32'(w));
    chk("img_h_stable", 32'(conv_img_height), 32'(h));
  endtask

  initial begin
    int l0;
    #1;
    chk("rst_ready", 32'(desc_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wtreq", 32'(wt_req), 0);
    chk("rst_start", 32'(conv_start), 0);
    chk("rst_tile", 32'(cur_tile), 0);
    chk("rst_img_w", 32'(conv_img_width_strips), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", 32'(desc_ready), 1);
    // single tile, done held three cycles
    run_layer(16'd4, 16'd6, 1, 1'b1, 0, 2, 3, 1'b0, 1'b0);
    // three tiles, slow weight acks
    run_layer(16'd9, 16'd12, 3, 1'b0, 5, 1, 1, 1'b0, 1'b0);
    // rejected descriptor keeps previous image size
    send_bad(1);
    send_bad(0);
    send_bad(2);
    // stale done on entry to start
    run_layer(16'd7, 16'd3, 2, 1'b1, 1, 0, 4, 1'b1, 1'b0);
    // watchdog abort after 20 run cycles
    l0 = n_ld;
    send_desc(16'd5, 16'd5, 1, 1'b1);
    wait_hi(0, "wd_wt_req");
    wt_ack = 1;
    @(negedge clk);
    wt_ack = 0;
    wait_hi(1, "wd_start");
    repeat (19) begin
      @(negedge clk);
      chk("wd_start_held", 32'(conv_start), 1);
      chk("wd_no_err", 32'(err_timeout), 0);
    end
    @(negedge clk);
    chk("wd_start_drop", 32'(conv_start), 0);
    chk("wd_err", 32'(err_timeout), 1);
    chk("wd_idle", 32'(busy), 0);
    chk("wd_ready", 32'(desc_ready), 1);
    @(negedge clk);
    chk("wd_err_pulse", 32'(err_timeout), 0);
    chk("wd_no_layer_done", 32'(n_ld - l0), 0);
    // maximum tile count
    run_layer(16'd1, 16'd1, 256, 1'b1, 0, 0, 1, 1'b0, 1'b0);
    // randomized layers interleaved with rejected descriptors
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0) send_bad(int'($urandom_range(0, 2)));
      run_layer(16'(1 + $urandom_range(0, 65534)), 16'(1 + $urandom_range(0, 65534)),
                int'($urandom_range(1, 5)), 1'($urandom), 0, 0, 1, 1'b0, 1'b1);
    end
    // reset during tile 1 of 4
    l0 = n_ld;
    send_desc(16'd8, 16'd8, 4, 1'b1);
    do_tile(0, 1, 1'b0, 1, 1, 1'b0, 1'b1);
    wait_hi(0, "mid_wt_req");
    wt_ack = 1;
    @(negedge clk);
    wt_ack = 0;
    wait_hi(1, "mid_start");
    rst_n = 0;
    #1;
    chk("mid_rst_start", 32'(conv_start), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(desc_ready), 0);
    chk("mid_rst_tile", 32'(cur_tile), 0);
    chk("mid_rst_img", 32'(conv_img_height), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(desc_ready), 1);
    chk("mid_rel_tile", 32'(cur_tile), 0);
    chk("mid_no_layer_done", 32'(n_ld - l0), 0);
    run_layer(16'd3, 16'd2, 2, 1'b0, 0, 1, 2, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
